// File: rtl/sync_dp_ram.sv
// sync_dp_ram: simple dual-port RAM (one write, one read port, one clock) with registered
// reads, optional output stage, and a post-reset engine that zeroes every word first.
module sync_dp_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter bit RD_MODE    = 1'b0,
  parameter bit OUT_REG    = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy
);
  // state | meaning
  // CLEAR | zeroing mem[clr_ptr] once per cycle; requests ignored; busy=1
  // READY | normal read/write traffic; terminal until next reset; busy=0

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   clr_ptr;
  logic                    clr_we;
  logic                    wr_acc;
  logic                    rd_acc;
  logic                    collide;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   s1_data;
  logic                    s1_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (clr_we) clr_ptr <= clr_ptr + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_ptr == LAST_ADDR) state_nxt = READY;
      READY:   state_nxt = READY;
      default: state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    busy    = (state == CLEAR);
    clr_we  = (state == CLEAR);
    wr_acc  = (state == READY) && wr_en;
    rd_acc  = (state == READY) && rd_en;
    collide = wr_acc && (wr_addr == rd_addr);
  end

  // Storage has no reset; the clear engine owns it until READY.
  always_ff @(posedge clock) begin
    if (clr_we)      mem[clr_ptr] <= '0;
    else if (wr_acc) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_acc;
      if (rd_acc) s1_data <= (RD_MODE && collide) ? wr_data : mem[rd_addr];
    end
  end

  generate
    if (OUT_REG) begin : g_out_reg
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          rd_valid <= 1'b0;
          rd_data  <= '0;
        end else begin
          rd_valid <= s1_valid;
          if (s1_valid) rd_data <= s1_data;
        end
      end
    end else begin : g_no_out_reg
      assign rd_valid = s1_valid;
      assign rd_data  = s1_data;
    end
  endgenerate

endmodule

// File: tb/tb_sync_dp_ram.sv
// Bench for sync_dp_ram: three instances (read-first/1-cycle, write-first/2-cycle,
// 32x64 defaults) driven in lock-step and compared to a queue-based reference model.
module tb_sync_dp_ram;
  localparam int DW = 8, AW = 4, DEPTH = 16;
  localparam int DW2 = 32, AW2 = 6, DEPTH2 = 64;

  logic clock = 1'b0;
  logic reset;
  logic          wr_en, rd_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data0, rd_data1;
  logic          rd_valid0, rd_valid1, busy0, busy1;
  logic           wr_en2, rd_en2;
  logic [AW2-1:0] wr_addr2, rd_addr2;
  logic [DW2-1:0] wr_data2, rd_data2;
  logic           rd_valid2, busy2;

  always #5 clock = ~clock;

  sync_dp_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_MODE(1'b0), .OUT_REG(1'b0)) dut0 (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0), .busy(busy0));

  sync_dp_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_MODE(1'b1), .OUT_REG(1'b1)) dut1 (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1), .busy(busy1));

  sync_dp_ram #(.DATA_WIDTH(DW2), .ADDR_WIDTH(AW2)) dut2 (
    .clock(clock), .reset(reset), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_valid(rd_valid2), .busy(busy2));

  typedef struct {int due; logic [DW-1:0] d;} pend_t;
  pend_t q0[$];
  pend_t q1[$];
  logic [DW-1:0]  ref_mem  [DEPTH];
  logic [DW2-1:0] ref_mem2 [DEPTH2];
  int edges, edge_no;
  logic exp_v0, exp_v1, exp_v2;
  logic [DW-1:0]  exp_d0, exp_d1;
  logic [DW2-1:0] exp_d2;
  int n_checks, n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    wr_en = 0; rd_en = 0; wr_addr = '0; rd_addr = '0; wr_data = '0;
    wr_en2 = 0; rd_en2 = 0; wr_addr2 = '0; rd_addr2 = '0; wr_data2 = '0;
  endtask

  // Reference behaviour for one rising edge, using the inputs currently applied.
  task automatic model_edge();
    logic [DW-1:0] old_v, new_v;
    bit ready, ready2;
    edge_no++;
    ready  = edges >= DEPTH;
    ready2 = edges >= DEPTH2;
    exp_v0 = 0; exp_v1 = 0; exp_v2 = 0;
    if (ready && rd_en) begin
      old_v = ref_mem[rd_addr];
      new_v = (wr_en && wr_addr == rd_addr) ? wr_data : old_v;
      q0.push_back('{due: edge_no, d: old_v});
      q1.push_back('{due: edge_no + 1, d: new_v});
    end
    if (ready && wr_en) ref_mem[wr_addr] = wr_data;
    if (ready2 && rd_en2) begin
      exp_v2 = 1;
      exp_d2 = ref_mem2[rd_addr2];
    end
    if (ready2 && wr_en2) ref_mem2[wr_addr2] = wr_data2;
    edges++;
    if (q0.size() > 0 && q0[0].due == edge_no) begin
      exp_v0 = 1; exp_d0 = q0[0].d; void'(q0.pop_front());
    end
    if (q1.size() > 0 && q1[0].due == edge_no) begin
      exp_v1 = 1; exp_d1 = q1[0].d; void'(q1.pop_front());
    end
  endtask

  task automatic step();
    @(posedge clock);
    if (!reset) model_edge();
    #1;
    chk("busy0", {31'd0, busy0}, (edges < DEPTH) ? 32'd1 : 32'd0);
    chk("busy1", {31'd0, busy1}, (edges < DEPTH) ? 32'd1 : 32'd0);
    chk("busy2", {31'd0, busy2}, (edges < DEPTH2) ? 32'd1 : 32'd0);
    chk("valid0", {31'd0, rd_valid0}, {31'd0, exp_v0});
    chk("valid1", {31'd0, rd_valid1}, {31'd0, exp_v1});
    chk("valid2", {31'd0, rd_valid2}, {31'd0, exp_v2});
    chk("data0", {24'd0, rd_data0}, {24'd0, exp_d0});
    chk("data1", {24'd0, rd_data1}, {24'd0, exp_d1});
    chk("data2", rd_data2, exp_d2);
  endtask

  task automatic do_reset();
    reset = 1;
    #1;
    chk("rst_valid0", {31'd0, rd_valid0}, 32'd0);
    chk("rst_valid1", {31'd0, rd_valid1}, 32'd0);
    chk("rst_busy0", {31'd0, busy0}, 32'd1);
    chk("rst_busy2", {31'd0, busy2}, 32'd1);
    chk("rst_data1", {24'd0, rd_data1}, 32'd0);
    edges = 0;
    q0.delete(); q1.delete();
    exp_v0 = 0; exp_v1 = 0; exp_v2 = 0;
    exp_d0 = '0; exp_d1 = '0; exp_d2 = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    for (int i = 0; i < DEPTH2; i++) ref_mem2[i] = '0;
    @(posedge clock);
    #1;
    reset = 0;
  endtask

  task automatic wait_ready(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    n_checks = 0; n_fail = 0; edge_no = 0;
    idle();
    do_reset();

    // Clear runs exactly DEPTH cycles, then every word reads back zero.
    wait_ready(DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      rd_en = 1; rd_addr = AW'(i); step();
    end
    idle(); step(); step();

    // Two writes, then back-to-back reads.
    wr_en = 1; wr_addr = 4'd3;  wr_data = 8'hA5; step();
    wr_en = 1; wr_addr = 4'd15; wr_data = 8'h3C; step();
    idle();
    rd_en = 1; rd_addr = 4'd3;  step();
    rd_en = 1; rd_addr = 4'd15; step();
    idle(); step(); step();

    // Same-address collision.
    wr_en = 1; wr_addr = 4'd7; wr_data = 8'h11; step();
    wr_en = 1; wr_addr = 4'd7; wr_data = 8'h22; rd_en = 1; rd_addr = 4'd7; step();
    idle();
    rd_en = 1; rd_addr = 4'd7; step();
    idle(); step(); step();

    // Requests while busy are dropped.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1; wr_addr = 4'd2; wr_data = 8'hFF; rd_en = 1; rd_addr = 4'd2;
      wr_en2 = 1; wr_addr2 = 6'd2; wr_data2 = 32'hFFFF_FFFF; rd_en2 = 1; rd_addr2 = 6'd2;
      step();
    end
    idle();
    wait_ready(DEPTH - 4);
    rd_en = 1; rd_addr = 4'd2; step();
    idle(); step(); step();

    // Reset during clear, then reset with a read in flight.
    do_reset();
    wait_ready(8);
    do_reset();
    wait_ready(DEPTH);
    wr_en = 1; wr_addr = 4'd9; wr_data = 8'h5A; step();
    idle();
    rd_en = 1; rd_addr = 4'd9; step();
    idle();
    do_reset();
    wait_ready(DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      rd_en = 1; rd_addr = AW'(i); step();
    end
    idle(); step(); step();

    // Wide instance: 64-cycle clear and a top-address round trip.
    wait_ready(DEPTH2 - DEPTH - 2);
    wr_en2 = 1; wr_addr2 = 6'd63; wr_data2 = 32'hDEAD_BEEF; step();
    idle();
    rd_en2 = 1; rd_addr2 = 6'd63; step();
    idle(); step();

    // Random traffic with frequent address collisions.
    for (int n = 0; n < 400; n++) begin
      wr_en   = 1'($urandom_range(0, 1));
      rd_en   = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom_range(0, DEPTH - 1));
      wr_data = DW'($urandom);
      rd_addr = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom_range(0, DEPTH - 1));
      wr_en2   = 1'($urandom_range(0, 1));
      rd_en2   = 1'($urandom_range(0, 1));
      wr_addr2 = AW2'($urandom_range(0, 7));
      wr_data2 = $urandom;
      rd_addr2 = AW2'($urandom_range(0, 7));
      step();
    end
    idle(); step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
